// File: rtl/phoenix_console_uart_pkg.sv
// Shared definitions for the console UART: bus encodings, register map,
// STATUS layout and transmitter state encodings.
package phoenix_console_uart_pkg;

  localparam logic DMI_READ  = 1'b0;
  localparam logic DMI_WRITE = 1'b1;

  localparam logic [31:0] TXDATA_OFS = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFS = 32'h0000_0004;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  function automatic logic [31:0] status_word(input logic full, input logic empty,
                                              input logic busy, input logic ovf,
                                              input logic [7:0] cnt);
    logic [31:0] w;
    w = '0;
    w[ST_FULL]            = full;
    w[ST_EMPTY]           = empty;
    w[ST_BUSY]            = busy;
    w[ST_OVF]             = ovf;
    w[ST_CNT_LSB +: 8]    = cnt;
    return w;
  endfunction

endpackage

// File: rtl/phoenix_console_uart_fifo.sv
// Transmit byte FIFO; a push into a full FIFO and a pop from an empty one
// are ignored.
module console_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [7:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] count_q, count_d;
  logic        do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/phoenix_console_uart.sv
// Memory-mapped console UART: TXDATA/STATUS registers on the data bus feeding
// a byte FIFO and an 8N1 serial transmitter.
module phoenix_console_uart
  import phoenix_console_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h1000_0000,
  parameter logic [15:0] CLKS_PER_BIT = 16'd868,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_memory_interface_enable,
  input  logic        data_memory_interface_state,
  input  logic [31:0] data_memory_interface_address,
  input  logic [3:0]  data_memory_interface_frame_mask,
  inout  wire  [31:0] data_memory_interface_data,
  output logic        uart_tx,
  output logic        tx_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic        sel_tx, sel_st, bus_wr, bus_rd, push, pop;
  logic        fifo_full, fifo_empty;
  logic [7:0]  fifo_dout, cnt8;
  logic [AW:0] fifo_count;
  logic [31:0] rd_data;
  logic        ovf_q, ovf_d;
  logic [1:0]  state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d, baud_last;
  logic        unused_bits;

  assign sel_tx = (data_memory_interface_address == BASE_ADDRESS + TXDATA_OFS);
  assign sel_st = (data_memory_interface_address == BASE_ADDRESS + STATUS_OFS);
  assign bus_wr = data_memory_interface_enable && (data_memory_interface_state == DMI_WRITE);
  assign bus_rd = data_memory_interface_enable && (data_memory_interface_state == DMI_READ);
  assign push   = bus_wr && sel_tx && data_memory_interface_frame_mask[3];
  assign unused_bits = ^{data_memory_interface_data[31:8], data_memory_interface_frame_mask[2:0]};

  console_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (data_memory_interface_data[7:0]),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign cnt8    = 8'(fifo_count);
  assign tx_busy = !fifo_empty || (state_q != S_IDLE);
  assign rd_data = sel_st ? status_word(fifo_full, fifo_empty, tx_busy, ovf_q, cnt8) : 32'h0;
  assign data_memory_interface_data = (bus_rd && (sel_tx || sel_st)) ? rd_data : 32'bz;

  always_comb begin
    ovf_d = ovf_q;
    if (push && fifo_full)
      ovf_d = 1'b1;
    else if (bus_wr && sel_st && data_memory_interface_frame_mask[3] && data_memory_interface_data[ST_OVF])
      ovf_d = 1'b0;
  end

  assign baud_last = (baud_q == CLKS_PER_BIT - 16'd1);
  assign pop = !fifo_empty && ((state_q == S_IDLE) || (state_q == S_STOP && baud_last));

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          shift_d = fifo_dout;
          state_d = S_START;
        end
      end
      S_START: if (baud_last) begin
        baud_d  = '0;
        bit_d   = '0;
        state_d = S_DATA;
      end
      S_DATA: if (baud_last) begin
        baud_d  = '0;
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = S_STOP;
      end
      default: if (baud_last) begin
        baud_d = '0;
        if (!fifo_empty) begin
          shift_d = fifo_dout;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // The line is registered, so it trails the state by one cycle.
  always_comb begin
    tx_d = 1'b1;
    if (state_q == S_START)     tx_d = 1'b0;
    else if (state_q == S_DATA) tx_d = shift_q[0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign uart_tx = tx_q;

endmodule

// File: tb/tb_phoenix_console_uart.sv
// Bench for phoenix_console_uart: serial line logged every cycle and decoded
// by a mid-bit sampling receiver, registers checked against expected values.
module tb_phoenix_console_uart;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] A_TX = BASE;
  localparam logic [31:0] A_ST = BASE + 32'h4;
  localparam logic [31:0] HIZ  = 32'hFFFF_FFFF;

  logic        clk = 1'b0, reset = 1'b0, en = 1'b0, st = 1'b0, tb_oe = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  mask = '0;
  wire  [31:0] bus;
  logic        uart_tx, tx_busy;

  assign bus = tb_oe ? wdata : 32'bz;
  for (genvar i = 0; i < 32; i++) begin : g_pu
    pullup (bus[i]);
  end

  phoenix_console_uart #(.BASE_ADDRESS(BASE), .CLKS_PER_BIT(16'(CPB)), .FIFO_DEPTH(DEPTH)) dut (
    .clk                              (clk),
    .reset                            (reset),
    .data_memory_interface_enable     (en),
    .data_memory_interface_state      (st),
    .data_memory_interface_address    (addr),
    .data_memory_interface_frame_mask (mask),
    .data_memory_interface_data       (bus),
    .uart_tx                          (uart_tx),
    .tx_busy                          (tx_busy)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic line_log [0:16383];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) line_log[cyc] <= uart_tx;

  int n_cmp = 0, n_bad = 0;

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  task automatic idle_bus();
    en = 1'b0; tb_oe = 1'b0; mask = '0; st = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Call just after a negedge; returns the index of the edge that sampled it.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                           output int edge_n);
    en = 1'b1; st = 1'b1; addr = a; wdata = d; mask = m; tb_oe = 1'b1;
    @(negedge clk);
    edge_n = cyc;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic ena, output logic [31:0] d);
    tb_oe = 1'b0; en = ena; st = 1'b0; addr = a; mask = 4'hF;
    #1 d = bus;
    @(negedge clk);
    idle_bus();
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (tx_busy === 1'b1 && k < 2000) begin
      @(negedge clk); k++;
    end
    n_cmp++;
    if (tx_busy !== 1'b0) begin
      n_bad++; $display("FAIL %s: tx_busy still %b after %0d cycles, want 0", name, tx_busy, k);
    end
    wait_cycles(2);
  endtask

  // Finds the next falling edge at or after 'from' and samples each bit mid-period.
  task automatic rx_frame(input int from, output logic [7:0] b, output int start, output logic ok);
    start = -1; ok = 1'b0; b = '0;
    for (int c = (from < 1 ? 1 : from); c + 10*CPB < cyc; c++) begin
      if (line_log[c] === 1'b0 && line_log[c-1] === 1'b1) begin start = c; break; end
    end
    if (start >= 0) begin
      for (int k = 0; k < 8; k++) b[k] = line_log[start + (k+1)*CPB + CPB/2];
      ok = (line_log[start + CPB/2] === 1'b0) && (line_log[start + 9*CPB + CPB/2] === 1'b1);
    end
  endtask

  task automatic check_status(input string name, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(A_ST, 1'b1, d);
    n_cmp++;
    if (d !== exp) begin
      n_bad++; $display("FAIL %s: STATUS got %h want %h", name, d, exp);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    idle_bus(); reset = 1'b0;
    wait_cycles(3);
    n_cmp++;
    if (uart_tx !== 1'b1 || tx_busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_outputs: uart_tx=%b tx_busy=%b want 1/0", uart_tx, tx_busy);
    end
    reset = 1'b1;
    wait_cycles(1);
    check_status("reset_status", 32'h0000_0002);
    bus_read(A_ST, 1'b0, d);
    n_cmp++;
    if (d !== HIZ) begin n_bad++; $display("FAIL reset_bus_z: bus %h want %h", d, HIZ); end
  endtask

  task automatic test_single_frame();
    int n;
    logic [7:0] b;
    b = 8'h41;
    bus_write(A_TX, 32'h0000_0041, 4'b1000, n);
    idle_bus();
    n_cmp++;
    if (tx_busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_rise: tx_busy %b want 1", tx_busy); end
    wait_cycles(1);
    n_cmp++;
    if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL single_n1_idle: uart_tx %b want 1", uart_tx); end
    for (int i = 0; i < 10*CPB; i++) begin
      wait_cycles(1);
      n_cmp++;
      if (uart_tx !== frame_bit(b, i / CPB)) begin
        n_bad++; $display("FAIL single_line[%0d]: uart_tx %b want %b", i, uart_tx, frame_bit(b, i / CPB));
      end
    end
    n_cmp++;
    if (tx_busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_fall: tx_busy %b want 0", tx_busy); end
    wait_cycles(2);
  endtask

  task automatic test_back_to_back();
    int n0, n, start, prev;
    logic [7:0] b;
    logic ok;
    for (int i = 0; i < 6; i++) begin
      bus_write(A_TX, 32'h30 + i, 4'b1000, n);
      if (i == 0) n0 = n;
    end
    idle_bus();
    // full, busy, overflow set, four entries queued
    check_status("b2b_status_full", 32'h0000_040D);
    wait_idle("b2b_drain");
    prev = n0 + 2 - 10*CPB;
    start = n0;
    for (int i = 0; i < 5; i++) begin
      rx_frame((i == 0) ? n0 : start + 10*CPB, b, start, ok);
      n_cmp++;
      if (!ok || b !== 8'(8'h30 + i) || start != prev + 10*CPB) begin
        n_bad++;
        $display("FAIL b2b_frame[%0d]: byte %h start %0d framing %b want %h start %0d", i, b, start, ok,
                 8'(8'h30 + i), prev + 10*CPB);
      end
      prev = start;
    end
    rx_frame(start + 10*CPB, b, start, ok);
    n_cmp++;
    if (start != -1) begin n_bad++; $display("FAIL b2b_extra_frame: start %0d byte %h want none", start, b); end
    check_status("b2b_status_drained", 32'h0000_000A);
  endtask

  task automatic test_overflow_clear();
    int n;
    bus_write(A_ST, 32'h0, 4'b1000, n); idle_bus();
    check_status("ovf_keep_data0", 32'h0000_000A);
    bus_write(A_ST, 32'h8, 4'b0100, n); idle_bus();
    check_status("ovf_keep_mask0100", 32'h0000_000A);
    bus_write(A_ST, 32'h8, 4'b1000, n); idle_bus();
    check_status("ovf_cleared", 32'h0000_0002);
    bus_write(A_TX, 32'h55, 4'b0100, n); idle_bus();
    check_status("mask0100_no_push", 32'h0000_0002);
    bus_write(BASE + 32'h8, 32'h55, 4'b1000, n); idle_bus();
    check_status("other_addr_no_push", 32'h0000_0002);
    wait_cycles(10);
    n_cmp++;
    if (tx_busy !== 1'b0 || uart_tx !== 1'b1) begin
      n_bad++; $display("FAIL no_push_line: tx_busy %b uart_tx %b want 0/1", tx_busy, uart_tx);
    end
  endtask

  task automatic test_bus_z();
    logic [31:0] d;
    bus_read(BASE + 32'h8, 1'b1, d);
    n_cmp++;
    if (d !== HIZ) begin n_bad++; $display("FAIL z_other_addr: bus %h want %h", d, HIZ); end
    bus_read(A_ST, 1'b0, d);
    n_cmp++;
    if (d !== HIZ) begin n_bad++; $display("FAIL z_disabled: bus %h want %h", d, HIZ); end
    bus_read(A_TX, 1'b1, d);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL txdata_read: bus %h want 00000000", d); end
    check_status("txdata_read_no_effect", 32'h0000_0002);
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [7:0] b, exp;
    logic ok;
    int n0, n, cnt, start, gap;
    for (int r = 0; r < 4; r++) begin
      q = {};
      cnt = $urandom_range(1, DEPTH + 1);
      for (int i = 0; i < cnt; i++) begin
        b = 8'($urandom);
        q.push_back(b);
        bus_write(A_TX, {24'($urandom), b}, 4'b1000 | 4'($urandom_range(0, 7)), n);
        if (i == 0) n0 = n;
        gap = $urandom_range(0, 2);
        if (gap > 0) begin idle_bus(); wait_cycles(gap); end
      end
      idle_bus();
      wait_idle("rand_drain");
      start = n0 - 10*CPB;
      while (q.size() > 0) begin
        exp = q.pop_front();
        rx_frame(start + 10*CPB < n0 ? n0 : start + 10*CPB, b, start, ok);
        n_cmp++;
        if (!ok || b !== exp) begin
          n_bad++; $display("FAIL rand_frame[r%0d]: byte %h framing %b want %h", r, b, ok, exp);
        end
      end
      check_status("rand_status_idle", 32'h0000_0002);
    end
  endtask

  task automatic test_reset_midframe();
    int n0, n;
    bus_write(A_TX, 32'h00, 4'b1000, n0);
    bus_write(A_TX, 32'h00, 4'b1000, n);
    bus_write(A_TX, 32'h00, 4'b1000, n);
    idle_bus();
    wait_cycles(14);
    n_cmp++;
    if (uart_tx !== 1'b0) begin n_bad++; $display("FAIL midframe_pre: uart_tx %b want 0", uart_tx); end
    reset = 1'b0;
    wait_cycles(1);
    n_cmp++;
    if (uart_tx !== 1'b1 || tx_busy !== 1'b0) begin
      n_bad++; $display("FAIL midframe_reset_edge: uart_tx %b tx_busy %b want 1/0", uart_tx, tx_busy);
    end
    wait_cycles(1);
    reset = 1'b1;
    wait_cycles(1);
    check_status("midframe_status", 32'h0000_0002);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      wait_cycles(1);
      if (uart_tx !== 1'b1 || tx_busy !== 1'b0) n++;
    end
    n_cmp++;
    if (n != 0) begin n_bad++; $display("FAIL midframe_discard: %0d non-idle cycles want 0", n); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow_clear();
    test_bus_z();
    test_random();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
